fifo_sync: RTL and testbench

//  Single-clock synchronous FIFO: a byte-wide (default) first-in first-out buffer of 2**ADDR_BITS

---
 rtl/fifo_sync_pkg.sv | 7 +
 rtl/fifo_sync.sv | 87 ++++++++
 tb/tb_fifo_sync.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_pkg.sv
// Shared defaults for the single-clock FIFO.
package fifo_sync_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_BITS  = 4;

endpackage : fifo_sync_pkg

// File: rtl/fifo_sync.sv
// Single-clock synchronous FIFO with full/empty flags and a registered read port.
// Pointers carry one extra wrap bit so full and empty can be told apart without a counter.
module fifo_sync
    import fifo_sync_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  w_en,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_empty,
    output logic                  fifo_full
);

    localparam int N_REGS = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] PTR_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    // Storage and pointer state (names are probed hierarchically by benches).
    logic [DATA_WIDTH-1:0] fifo_mem_reg [0:N_REGS-1];
    logic [ADDR_BITS:0]    w_ptr_r;
    logic [ADDR_BITS:0]    r_ptr_r;
    logic                  w_en_r;
    logic                  r_en_r;

    logic [ADDR_BITS:0]    w_ptr_d;
    logic [ADDR_BITS:0]    r_ptr_d;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [ADDR_BITS-1:0]  w_addr;
    logic [ADDR_BITS-1:0]  r_addr;

    assign w_addr = w_ptr_r[ADDR_BITS-1:0];
    assign r_addr = r_ptr_r[ADDR_BITS-1:0];

    // Status flags straight from the pointers: equal means empty, same slot on opposite laps means full.
    assign fifo_empty = (w_ptr_r == r_ptr_r);
    assign fifo_full  = (w_addr == r_addr) && (w_ptr_r[ADDR_BITS] != r_ptr_r[ADDR_BITS]);

    // A read frees a slot in the same edge, so a full FIFO may still take a write alongside a read.
    // An empty FIFO never accepts a read, so there is no write-to-read bypass.
    assign rd_accept = r_en && !fifo_empty;
    assign wr_accept = w_en && (!fifo_full || rd_accept);

    // Next-state pointers; each advances by one on an accepted operation, wrapping modulo 2**(ADDR_BITS+1).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_ptr_d = w_ptr_r;
        r_ptr_d = r_ptr_r;
        if (wr_accept) w_ptr_d = w_ptr_r + PTR_ONE;
        if (rd_accept) r_ptr_d = r_ptr_r + PTR_ONE;
    end

    // Pointer, read-data and debug enable registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            w_ptr_r  <= '0;
            r_ptr_r  <= '0;
            data_out <= '0;
            w_en_r   <= 1'b0;
            r_en_r   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values,
            // which is what lets a full-FIFO read return the old word while the same slot is rewritten.
            w_ptr_r <= w_ptr_d;
            r_ptr_r <= r_ptr_d;
            w_en_r  <= w_en;
            r_en_r  <= r_en;
            if (rd_accept) data_out <= fifo_mem_reg[r_addr];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            // NOTE: the array is cleared on reset because its contents are observable after reset;
            // this costs a reset net on every storage flop and rules out inferring a RAM macro.
            for (int i = 0; i < N_REGS; i++) fifo_mem_reg[i] <= '0;
        end else if (wr_accept) begin
            fifo_mem_reg[w_addr] <= data_in;
        end
    end

endmodule : fifo_sync

// File: tb/tb_fifo_sync.sv
// Directed/random bench for fifo_sync with a queue reference model and read-data scoreboard.
module tb_fifo_sync;

    logic       clk_i;
    logic       resetn_i;
    logic [7:0] data_in;
    logic       w_en;
    logic       r_en;
    logic [7:0] data_out;
    logic       fifo_empty;
    logic       fifo_full;

    fifo_sync dut (
        .clk_i      (clk_i),
        .resetn_i   (resetn_i),
        .data_in    (data_in),
        .w_en       (w_en),
        .r_en       (r_en),
        .data_out   (data_out),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] model_q [$];   // reference FIFO contents
    logic [7:0] exp_q   [$];   // scoreboard: expected read data awaiting the DUT
    logic [7:0] last_dout;
    logic [4:0] wptr_exp;
    logic [4:0] rptr_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        bit rd_ok;
        bit wr_ok;
        w_en    = w;
        r_en    = r;
        data_in = d;
        rd_ok = r && (model_q.size() != 0);
        wr_ok = w && ((model_q.size() != 16) || rd_ok);
        if (rd_ok) exp_q.push_back(model_q.pop_front());
        if (wr_ok) model_q.push_back(d);
        @(posedge clk_i);
        #1;
        if (rd_ok) begin
            last_dout = exp_q.pop_front();
            rptr_exp  = rptr_exp + 5'd1;
        end
        if (wr_ok) wptr_exp = wptr_exp + 5'd1;
        chk("data_out",   data_out,   last_dout);
        chk("fifo_empty", fifo_empty, model_q.size() == 0);
        chk("fifo_full",  fifo_full,  model_q.size() == 16);
        chk("w_ptr_r",    dut.w_ptr_r, wptr_exp);
        chk("r_ptr_r",    dut.r_ptr_r, rptr_exp);
        chk("w_en_r",     dut.w_en_r,  w);
        chk("r_en_r",     dut.r_en_r,  r);
    endtask

    // Asynchronous reset: asserted between edges, checked before any clock edge occurs.
    task automatic do_reset();
        #2;
        resetn_i = 1'b0;
        #1;
        model_q.delete();
        exp_q.delete();
        last_dout = 8'h00;
        wptr_exp  = '0;
        rptr_exp  = '0;
        chk("rst_w_ptr",  dut.w_ptr_r, 0);
        chk("rst_r_ptr",  dut.r_ptr_r, 0);
        chk("rst_empty",  fifo_empty,  1);
        chk("rst_full",   fifo_full,   0);
        chk("rst_dout",   data_out,    0);
        chk("rst_mem0",   dut.fifo_mem_reg[0], 0);
        @(posedge clk_i);
        #1;
        resetn_i = 1'b1;
    endtask

    initial begin
        logic [7:0] first_byte;
        logic       w_state;
        logic       r_state;
        int         w_hold;
        int         r_hold;

        resetn_i  = 1'b1;
        w_en      = 1'b0;
        r_en      = 1'b0;
        data_in   = 8'h00;
        last_dout = 8'h00;
        wptr_exp  = '0;
        rptr_exp  = '0;

        // 1. Reset, then idle.
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 8'($urandom));

        // 2. Write-only burst to full, then one dropped write.
        first_byte = 8'($urandom);
        cycle(1'b1, 1'b0, first_byte);
        for (int i = 1; i < 16; i++) cycle(1'b1, 1'b0, 8'($urandom));
        chk("burst_full", fifo_full, 1);
        chk("burst_wptr", dut.w_ptr_r, 16);
        cycle(1'b1, 1'b0, ~first_byte);
        chk("drop_wptr", dut.w_ptr_r, 16);
        chk("drop_mem0", dut.fifo_mem_reg[0], first_byte);

        // 3. Drain in order, then reads on empty leave data_out alone.
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
        chk("drain_empty", fifo_empty, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h00);
        chk("drain_rptr", dut.r_ptr_r, 16);

        // 4. Continuous simultaneous read/write from empty.
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 8'($urandom));

        // 5. Reads only on an empty FIFO after reset.
        do_reset();
        for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 8'($urandom));

        // 6. Random unaligned enable toggling, then reset mid-stream.
        w_state = 1'b1;
        r_state = 1'b0;
        w_hold  = $urandom_range(0, 15);
        r_hold  = $urandom_range(0, 15);
        for (int i = 0; i < 400; i++) begin
            cycle(w_state, r_state, 8'($urandom));
            if (w_hold == 0) begin
                w_state = ~w_state;
                w_hold  = $urandom_range(0, 15);
            end else begin
                w_hold--;
            end
            if (r_hold == 0) begin
                r_state = ~r_state;
                r_hold  = $urandom_range(0, 15);
            end else begin
                r_hold--;
            end
        end
        // Make sure the FIFO is non-empty so the mid-stream reset visibly clears it.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'($urandom));
        chk("pre_rst_nonempty", fifo_empty, 0);
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fifo_sync
